// File: rtl/decoder_pkg.sv
// Shared constants, one-hot helper and the elaboration-time parameter check
// used by decoder and decoder_pipe.
package decoder_pkg;

  localparam int MAX_CH   = 4;
  localparam int MAX_OH_W = 256;

  // One-hot of sel within a width-bit field; all zeros when sel is out of range.
  function automatic logic [MAX_OH_W-1:0] onehot(input int unsigned sel,
                                                 input int unsigned width);
    logic [MAX_OH_W-1:0] r;
    r = '0;
    if (sel < width && sel < MAX_OH_W)
      r = {{(MAX_OH_W-1){1'b0}}, 1'b1} << sel;
    return r;
  endfunction

endpackage

`ifndef DECODER_PARAM_CHECK
`define DECODER_PARAM_CHECK(BSI, BSO, NCH) \
  if (((BSO) > (2 ** (BSI))) || ((NCH) > decoder_pkg::MAX_CH) || ((NCH) < 1) || ((BSO) > decoder_pkg::MAX_OH_W)) begin : g_param_err \
    $fatal(1, "decoder: illegal parameter combination"); \
  end
`endif

// File: rtl/decoder.sv
// Combinational per-channel decoder: select/enable to one-hot plus a flag for
// an enabled select that falls outside the output vector.
module decoder
  import decoder_pkg::*;
#(
  parameter int bus_size_in  = 3,
  parameter int bus_size_out = 8
) (
  input  logic [bus_size_in-1:0]  sel,
  input  logic                    en,
  output logic [bus_size_out-1:0] hot,
  output logic                    range_err
);

  logic [MAX_OH_W-1:0] full;

  always_comb begin
    full      = onehot(32'(sel), bus_size_out);
    hot       = en ? full[bus_size_out-1:0] : '0;
    range_err = en && (32'(sel) >= 32'(bus_size_out));
  end

  generate
    if (bus_size_out < MAX_OH_W) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^full[MAX_OH_W-1:bus_size_out];
    end
  endgenerate

endmodule

// File: rtl/decoder_pipe.sv
// Multi-channel priority decoder with a 1-deep valid/ready output register.
// Optional saturating error counter enabled by DECODER_PIPE_ERR_CNT_EN.
module decoder_pipe
  import decoder_pkg::*;
#(
  parameter int bus_size_in  = 3,
  parameter int bus_size_out = 8,
  parameter int num_ch       = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [num_ch*bus_size_in-1:0] select,
  input  logic [num_ch-1:0]             enabled,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [bus_size_out-1:0]       out,
  output logic [num_ch-1:0]             collision,
  output logic [num_ch-1:0]             range_err,
  output logic [7:0]                    err_count
);

  generate
    `DECODER_PARAM_CHECK(bus_size_in, bus_size_out, num_ch)
  endgenerate

  logic [bus_size_out-1:0] hot_p0 [num_ch];
  logic [num_ch-1:0]       rerr_p0;
  logic [num_ch-1:0]       coll_p0;
  logic [bus_size_out-1:0] merged_p0;
  logic                    accept;

  genvar c;
  generate
    for (c = 0; c < num_ch; c++) begin : g_dec
      decoder #(
        .bus_size_in (bus_size_in),
        .bus_size_out(bus_size_out)
      ) u_dec (
        .sel      (select[c*bus_size_in +: bus_size_in]),
        .en       (enabled[c]),
        .hot      (hot_p0[c]),
        .range_err(rerr_p0[c])
      );
    end
  endgenerate

  // Stage 0: fixed-priority merge, lower channel index wins a shared bit
  always_comb begin
    merged_p0 = '0;
    coll_p0   = '0;
    for (int i = 0; i < num_ch; i++) begin
      if (|(hot_p0[i] & merged_p0))
        coll_p0[i] = 1'b1;
      else
        merged_p0 = merged_p0 | hot_p0[i];
    end
  end

  logic                    vld_p1;
  logic [bus_size_out-1:0] out_p1;
  logic [num_ch-1:0]       coll_p1;
  logic [num_ch-1:0]       rerr_p1;

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;

  // Stage 1: output register, loads only on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p1  <= '0;
      coll_p1 <= '0;
      rerr_p1 <= '0;
    end else if (accept) begin
      out_p1  <= merged_p0;
      coll_p1 <= coll_p0;
      rerr_p1 <= rerr_p0;
    end
  end

  assign out_valid = vld_p1;
  assign out       = out_p1;
  assign collision = coll_p1;
  assign range_err = rerr_p1;

`ifdef DECODER_PIPE_ERR_CNT_EN
  logic [7:0] cnt_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1 <= '0;
    end else if (accept && ((|coll_p0) || (|rerr_p0)) && (cnt_p1 != 8'hFF)) begin
      cnt_p1 <= cnt_p1 + 8'd1;
    end
  end

  assign err_count = cnt_p1;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed bench for decoder_pipe: an 8-output and a 6-output instance,
// each scenario in its own task with inline checks.
module tb_decoder_pipe;

`ifdef DECODER_PIPE_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] select = '0;
  logic [1:0] enabled = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out;
  logic [1:0] collision;
  logic [1:0] range_err;
  logic [7:0] err_count;

  logic       b_in_valid = 1'b0;
  logic       b_in_ready;
  logic [5:0] b_select = '0;
  logic [1:0] b_enabled = '0;
  logic       b_out_valid;
  logic       b_out_ready = 1'b1;
  logic [5:0] b_out;
  logic [1:0] b_collision;
  logic [1:0] b_range_err;
  logic [7:0] b_err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder_pipe #(.bus_size_in(3), .bus_size_out(8), .num_ch(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .select(select), .enabled(enabled), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .collision(collision),
    .range_err(range_err), .err_count(err_count)
  );

  decoder_pipe #(.bus_size_in(3), .bus_size_out(6), .num_ch(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .select(b_select), .enabled(b_enabled), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out(b_out), .collision(b_collision),
    .range_err(b_range_err), .err_count(b_err_count)
  );

  // Presents one bundle with out_ready=1, lets it be accepted, samples 1ns later.
  task automatic send(input logic [2:0] s0, input logic [2:0] s1, input logic [1:0] en);
    @(negedge clk);
    in_valid  = 1'b1;
    select    = {s1, s0};
    enabled   = en;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out got %h exp 00", out); end
    checks++; if (collision !== 2'b00) begin errors++; $display("FAIL reset_coll got %b exp 00", collision); end
    checks++; if (range_err !== 2'b00) begin errors++; $display("FAIL reset_rerr got %b exp 00", range_err); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_errcnt got %0d exp 0", err_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;

    // accept a bundle, hold it with backpressure, then reset asynchronously
    @(negedge clk);
    in_valid = 1'b1; select = {3'd0, 3'd5}; enabled = 2'b01; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out !== 8'b0010_0000) begin errors++; $display("FAIL midrst_pre got v=%b out=%b exp v=1 out=00100000", out_valid, out); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", out_valid); end
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL midrst_out got %h exp 00", out); end
    @(negedge clk);
    rst_n = 1'b1;

    send(3'd3, 3'd0, 2'b01);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL postrst_valid got %b exp 1", out_valid); end
    checks++; if (out !== 8'b0000_1000) begin errors++; $display("FAIL postrst_out got %b exp 00001000", out); end
  endtask

  task automatic test_distinct();
    send(3'd5, 3'd2, 2'b11);
    checks++; if (out !== 8'b0010_0100) begin errors++; $display("FAIL distinct_out got %b exp 00100100", out); end
    checks++; if (collision !== 2'b00) begin errors++; $display("FAIL distinct_coll got %b exp 00", collision); end
    checks++; if (range_err !== 2'b00) begin errors++; $display("FAIL distinct_rerr got %b exp 00", range_err); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL distinct_errcnt got %0d exp 0", err_count); end
    send(3'd0, 3'd7, 2'b10);
    checks++; if (out !== 8'b1000_0000) begin errors++; $display("FAIL ch1_only_out got %b exp 10000000", out); end
  endtask

  task automatic test_collision();
    send(3'd6, 3'd6, 2'b11);
    checks++; if (out !== 8'b0100_0000) begin errors++; $display("FAIL coll_out got %b exp 01000000", out); end
    checks++; if (collision !== 2'b10) begin errors++; $display("FAIL coll_bits got %b exp 10", collision); end
    checks++; if (range_err !== 2'b00) begin errors++; $display("FAIL coll_rerr got %b exp 00", range_err); end
    checks++; if (err_count !== (ERR_EN ? 8'd1 : 8'd0)) begin errors++; $display("FAIL coll_errcnt got %0d exp %0d", err_count, ERR_EN ? 1 : 0); end
  endtask

  task automatic test_all_disabled();
    send(3'd4, 3'd4, 2'b00);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL nowrite_valid got %b exp 1", out_valid); end
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL nowrite_out got %h exp 00", out); end
    checks++; if (collision !== 2'b00) begin errors++; $display("FAIL nowrite_coll got %b exp 00", collision); end
  endtask

  task automatic test_range();
    @(negedge clk);
    b_in_valid = 1'b1; b_select = {3'd0, 3'd7}; b_enabled = 2'b01;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL range_valid got %b exp 1", b_out_valid); end
    checks++; if (b_out !== 6'b00_0000) begin errors++; $display("FAIL range_out got %b exp 000000", b_out); end
    checks++; if (b_range_err !== 2'b01) begin errors++; $display("FAIL range_bits got %b exp 01", b_range_err); end
    checks++; if (b_err_count !== (ERR_EN ? 8'd1 : 8'd0)) begin errors++; $display("FAIL range_errcnt got %0d exp %0d", b_err_count, ERR_EN ? 1 : 0); end
    @(negedge clk);
    b_in_valid = 1'b1; b_select = {3'd5, 3'd6}; b_enabled = 2'b11;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    checks++; if (b_out !== 6'b10_0000) begin errors++; $display("FAIL range_edge_out got %b exp 100000", b_out); end
    checks++; if (b_range_err !== 2'b01 || b_collision !== 2'b00) begin errors++; $display("FAIL range_edge_flags got r=%b c=%b exp r=01 c=00", b_range_err, b_collision); end
    @(negedge clk);
    b_in_valid = 1'b1; b_select = {3'd7, 3'd7}; b_enabled = 2'b00;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    checks++; if (b_range_err !== 2'b00 || b_out !== 6'd0) begin errors++; $display("FAIL range_disabled got r=%b out=%b exp r=00 out=000000", b_range_err, b_out); end
    checks++; if (b_err_count !== (ERR_EN ? 8'd2 : 8'd0)) begin errors++; $display("FAIL range_errcnt2 got %0d exp %0d", b_err_count, ERR_EN ? 2 : 0); end
  endtask

  task automatic test_backpressure();
    // bundle X accepted while downstream stalls
    @(negedge clk);
    in_valid = 1'b1; select = {3'd0, 3'd1}; enabled = 2'b01; out_ready = 1'b0;
    @(posedge clk);
    // bundle Y waits for 3 stalled cycles
    @(negedge clk);
    select = {3'd0, 3'd4}; enabled = 2'b01;
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, in_ready); end
      checks++; if (out !== 8'b0000_0010 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d] got v=%b out=%b exp v=1 out=00000010", i, out_valid, out); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1 || out !== 8'b0001_0000) begin errors++; $display("FAIL bp_y got v=%b out=%b exp v=1 out=00010000", out_valid, out); end
    @(negedge clk);
    select = {3'd2, 3'd0}; enabled = 2'b11;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b1 || out !== 8'b0000_0101) begin errors++; $display("FAIL bp_z got v=%b out=%b exp v=1 out=00000101", out_valid, out); end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", out_valid); end
    checks++; if (out !== 8'b0000_0101) begin errors++; $display("FAIL bp_drain_out got %b exp 00000101", out); end
  endtask

`ifdef DECODER_PIPE_ERR_CNT_EN
  task automatic test_saturation();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL sat_reset got %0d exp 0", err_count); end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; select = {3'd3, 3'd3}; enabled = 2'b11; out_ready = 1'b1;
    repeat (254) @(posedge clk);
    #1;
    checks++; if (err_count !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d exp 254", err_count); end
    repeat (46) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d exp 255", err_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_distinct();
    test_collision();
    test_all_disabled();
    test_range();
    test_backpressure();
`ifdef DECODER_PIPE_ERR_CNT_EN
    test_saturation();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_pipe.md
Name: decoder_pipe

Overview:
- Registered, multi-channel, parametrised successor to the combinational `decoder`.
- Takes `num_ch` independent select/enable pairs and decodes each into a one-hot.
- Resolves conflicts by fixed priority and merges the results into one `bus_size_out` enable vector.
- Presents the result through a 1-deep valid/ready pipeline stage; its primary use is register-file write-enable generation with multiple write-back ports.

Parameters:
- bus_size_in, 3, select width per channel.
- bus_size_out, 8, output vector width; must satisfy bus_size_out <= 2**bus_size_in.
- num_ch, 2, number of request channels (1..4); channel 0 has the highest priority.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request bundle valid
- in_ready  output  1  stage can accept a bundle
- select  input  num_ch*bus_size_in  channel c occupies bits [c*bus_size_in +: bus_size_in]
- enabled  input  num_ch  per-channel enable
- out_valid  output  1  registered result valid
- out_ready  input  1  downstream accepts the result
- out  output  bus_size_out  merged one-hot enable vector
- collision  output  num_ch  bit c set if channel c was dropped because a higher-priority channel chose the same index
- range_err  output  num_ch  bit c set if channel c was enabled with select >= bus_size_out
- err_count  output  8  saturating error counter (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out=0, collision=0, range_err=0, err_count=0.
  - Any in-flight result is discarded. The first valid bundle after release is accepted normally.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; no bubble on a continuous stream).
  - Accept occurs when in_valid && in_ready at a rising clk edge.
  - out_valid rises on the edge after accept (latency 1).
  - out_valid clears on out_ready with no new accept; it holds when the accept and the drain happen in the same cycle.
  - out, collision and range_err are stable while out_valid && !out_ready.
- Per-channel decode:
  - Channel disabled: contributes nothing; collision and range_err bits are 0.
  - Enabled with select >= bus_size_out: contributes nothing; range_err[c]=1.
  - Otherwise: one-hot bit 1<<select.
- Priority merge:
  - Process channels 0..num_ch-1 in order.
  - A channel whose bit is already set by a lower-numbered channel is dropped and its collision bit is set.
  - Result: out has at most num_ch bits set and never more than one bit per channel.
- All enables 0: out=0, out_valid still asserts (a valid "no write" bundle).
- num_ch=1: collision is always 0.
- No state machine beyond the valid flag. The stage register updates only on accept.

Optional Feature:
- Macro: DECODER_PIPE_ERR_CNT_EN.
- Defined:
  - err_count increments by 1 per accepted bundle with any collision or range_err bit set.
  - It saturates at 255 and is cleared only by reset.
  - It updates on the accept edge.
- Undefined: err_count is tied to 0 and no counter flops are built. The port is present in both builds.

Decomposition:
- Shared package/include `decoder_pkg`:
  - Constant MAX_CH=4.
  - Function onehot(sel, width), returning 0 when out of range.
  - A parameter-check macro asserting bus_size_out <= 2**bus_size_in and num_ch <= MAX_CH at elaboration.
- Sub-module: instantiate the existing combinational `decoder` once per channel (generate loop) for the one-hot stage.
  - Priority merge and the pipeline register stay in decoder_pipe.

Test Plan:
- Reset mid-stream: bundle accepted, rst_n pulsed low before out_ready -> out_valid=0, out=0 immediately (async). Next bundle sel0=3, en=01 -> out=8'b00001000 one cycle after accept.
- Two channels, distinct indices: sel0=5, sel1=2, en=11 -> out=8'b00100100, collision=00, range_err=00.
- Collision: sel0=6, sel1=6, en=11 -> out=8'b01000000, collision=10; err_count=1 with DECODER_PIPE_ERR_CNT_EN, 0 without.
- Range error: bus_size_out=6, sel0=7, en=01 -> out=0, range_err=01, out_valid=1.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out held constant. out_ready=1 -> in_ready=1, next bundle accepted the same cycle, out updates the next edge with no bubble.
- Saturation (macro on): 300 colliding bundles -> err_count=255.
